stream_scheduler: RTL and testbench
===================================

STREAM_SCHEDULER -- requirements
Module: stream_scheduler

Interface
REQ-001 Parameter HEADER_EN, default 1: when 1, each word is preceded by a stream-ID header byte; when 0, no header is sent.
REQ-002 Parameter HDR_TAG, default 5'b10100: upper 5 bits of the header byte.
REQ-003 clock  input  1  sole clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 ds_sending_flag  input  1  data streaming enabled.
REQ-006 stream_select  input  8  per-stream enable mask.
REQ-007 fifo_empty  input  8  per-stream FIFO empty.
REQ-008 fifo_dout_bus  input  128  stream i data on bits [16i+15:16i]; valid 1 cycle after its rd_en.
REQ-009 fifo_rd_en  output  8  one-hot read strobe.
REQ-010 tx_data  output  8  byte to the UART transmitter.
REQ-011 tx_start  output  1  one-cycle request to send tx_data.
REQ-012 tx_done  input  1  one-cycle pulse from the transmitter when the byte is finished.
REQ-013 cur_stream  output  3  stream currently granted.
REQ-014 sched_active  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, SCAN, READ, CAPTURE, SEND_HDR, WAIT_HDR, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
REQ-016 Transitions out of IDLE and SCAN:
- IDLE -> SCAN when ds_sending_flag=1.
- SCAN -> IDLE when ds_sending_flag=0.
REQ-017 Eligibility and grant in SCAN:
- Stream i is eligible when stream_select[i]=1 and fifo_empty[i]=0.
- Search order is last_grant+1 upward, wrapping 7->0; the first eligible stream wins.
- The winner is registered into cur_stream and last_grant; the FSM goes to READ.
- With no eligible stream, the FSM stays in SCAN.
REQ-018 READ:
- If fifo_empty[cur_stream]=0, assert fifo_rd_en[cur_stream] for exactly this one cycle and go to CAPTURE.
- Otherwise go back to SCAN with no strobe.
REQ-019 CAPTURE: latch fifo_dout_bus[16*cur_stream +: 16] into a 16-bit word register; go to SEND_HDR if HEADER_EN=1, else SEND_HI.
REQ-020 Send states:
- SEND_x drives tx_data and asserts tx_start for one cycle, then goes to WAIT_x.
- The header byte is {HDR_TAG, cur_stream}.
- The high byte is word[15:8]; the low byte is word[7:0].
REQ-021 Wait states: WAIT_x holds tx_data stable and leaves only on tx_done=1.
- WAIT_HDR -> SEND_HI.
- WAIT_HI -> SEND_LO.
- WAIT_LO -> SCAN if ds_sending_flag=1, else IDLE.
REQ-022 tx_done pulses received outside the WAIT states are ignored.
REQ-023 Once CAPTURE has been entered, the word is always sent in full. Deasserting ds_sending_flag or changing stream_select mid-word does not abort it; both are sampled only in IDLE, SCAN and at WAIT_LO exit.
REQ-024 Latency: eligible stream in a SCAN cycle -> rd_en in cycle +1 -> first tx_start in cycle +3.
REQ-025 Strobe limits: at most one fifo_rd_en bit is high in any cycle, and tx_start is never high in two consecutive cycles.
REQ-026 If a single stream stays eligible continuously, it is re-granted every word. If several are eligible, each is served once before any is served twice.

Reset
REQ-027 With reset=1 at a rising edge, the block enters IDLE. Reset takes priority over all other inputs in any state, including mid-word; the partial word is discarded.
REQ-028 Reset values: fifo_rd_en=0, tx_start=0, tx_data=0, cur_stream=0, sched_active=0, word register=0.
REQ-029 last_grant resets to 7, so the first grant after reset is the lowest-numbered eligible stream starting from 0.

Verification
REQ-030 Single word, header enabled:
- Stimulus: HEADER_EN=1, flag=1, select=8'h04, stream 2 holds 16'hBEEF, tx_done returned 5 cycles after each tx_start.
- Response: bytes A2, BE, EF in that order; one rd_en[2] pulse; tx_start exactly 3 cycles after the SCAN grant.
REQ-031 Round-robin:
- Stimulus: select=8'hFF; streams 1, 3 and 6 each hold 2 words.
- Response: grant order 1, 3, 6, 1, 3, 6, then SCAN idles with no rd_en.
REQ-032 Header disabled, back-to-back:
- Stimulus: HEADER_EN=0; stream 0 holds 16'h1234, 16'h5678.
- Response: bytes 12, 34, 56, 78; no header bytes.
REQ-033 Flag dropped mid-word:
- Stimulus: flag goes to 0 during WAIT_HI.
- Response: low byte is still sent; FSM is in IDLE the cycle after WAIT_LO exit; no further rd_en.
REQ-034 Reset mid-word:
- Stimulus: reset asserted during WAIT_HI.
- Response: next cycle shows IDLE with all outputs 0; a stray tx_done is ignored; after reset release, the first grant is the lowest eligible stream.
REQ-035 Masking and strobe legality:
- Stimulus: select=8'h00 while all FIFOs are non-empty; then a stray tx_done in SCAN.
- Response: no rd_en, no tx_start, no state change.

Source files
------------

// File: rtl/stream_scheduler.sv
// stream_scheduler: round-robin picks one 16-bit word at a time from 8 FIFOs and sends it as UART bytes, with an optional stream-ID header byte
module stream_scheduler #(
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [4:0] HDR_TAG   = 5'b10100
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ds_sending_flag,
  input  logic [7:0]   stream_select,
  input  logic [7:0]   fifo_empty,
  input  logic [127:0] fifo_dout_bus,
  output logic [7:0]   fifo_rd_en,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_done,
  output logic [2:0]   cur_stream,
  output logic         sched_active
);
  typedef enum logic [3:0] {
    IDLE, SCAN, READ, CAPTURE, SEND_HDR, WAIT_HDR, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
  } state_t;
  state_t      state_q, state_d;
  logic [2:0]  cur_q, cur_d, last_q, last_d, pick;
  logic [15:0] word_q, word_d, cap;
  logic [7:0]  tx_data_q, tx_data_d, elig;
  logic        tx_start_q, tx_start_d;
  always_comb begin
    elig = stream_select & ~fifo_empty;
    cap  = fifo_dout_bus[{cur_q, 4'b0000} +: 16];
    pick = last_q;
    for (int k = 8; k >= 1; k--) if (elig[last_q + 3'(k)]) pick = last_q + 3'(k);
  end
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: state_d = ds_sending_flag ? SCAN : IDLE;
      SCAN: begin
        if (!ds_sending_flag) state_d = IDLE;
        else if (|elig) begin
          cur_d   = pick;
          last_d  = pick;
          state_d = READ;
        end
      end
      READ: state_d = fifo_empty[cur_q] ? SCAN : CAPTURE;
      CAPTURE: begin
        word_d     = cap;
        tx_start_d = 1'b1;
        state_d    = HEADER_EN ? SEND_HDR : SEND_HI;
        tx_data_d  = HEADER_EN ? {HDR_TAG, cur_q} : cap[15:8];
      end
      SEND_HDR: state_d = WAIT_HDR;
      WAIT_HDR: begin
        if (tx_done) begin
          state_d    = SEND_HI;
          tx_data_d  = word_q[15:8];
          tx_start_d = 1'b1;
        end
      end
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_done) begin
          state_d    = SEND_LO;
          tx_data_d  = word_q[7:0];
          tx_start_d = 1'b1;
        end
      end
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (tx_done) state_d = ds_sending_flag ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= 3'd0;
      last_q     <= 3'd7;
      word_q     <= 16'h0000;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end
  assign fifo_rd_en   = (state_q == READ && !fifo_empty[cur_q]) ? 8'(1) << cur_q : 8'h00;
  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign cur_stream   = cur_q;
  assign sched_active = state_q != IDLE;
endmodule

// File: tb/tb_stream_scheduler.sv
// tb_stream_scheduler: directed checks of the stream scheduler with and without header bytes
module tb_stream_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, flag0, flag1, tx_done;
  logic [7:0] sel, fe;
  logic [127:0] dout;
  logic [7:0] rd0, rd1, txd0, txd1;
  logic txs0, txs1, act0, act1;
  logic [2:0] cur0, cur1;
  stream_scheduler #(.HEADER_EN(1'b1)) u1 (
    .clock(clk), .reset(reset), .ds_sending_flag(flag1), .stream_select(sel),
    .fifo_empty(fe), .fifo_dout_bus(dout), .fifo_rd_en(rd1), .tx_data(txd1),
    .tx_start(txs1), .tx_done(tx_done), .cur_stream(cur1), .sched_active(act1)
  );
  stream_scheduler #(.HEADER_EN(1'b0)) u0 (
    .clock(clk), .reset(reset), .ds_sending_flag(flag0), .stream_select(sel),
    .fifo_empty(fe), .fifo_dout_bus(dout), .fifo_rd_en(rd0), .tx_data(txd0),
    .tx_start(txs0), .tx_done(tx_done), .cur_stream(cur0), .sched_active(act0)
  );
  logic [15:0] mem [8][16];
  int wp [8];
  int rp [8];
  always_comb for (int i = 0; i < 8; i++) fe[i] = (wp[i] == rp[i]);
  initial begin
    dout = '0;
    for (int i = 0; i < 8; i++) rp[i] = 0;
  end
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rd0[i] | rd1[i]) begin
        dout[16*i +: 16] <= mem[i][rp[i]];
        rp[i] <= rp[i] + 1;
      end
    end
  end
  int total = 0, bad = 0, cyc = 0, cd = 0, viol = 0, s;
  bit auto_on = 1, stray = 0, use0 = 0, prev_s = 0;
  logic [7:0] bytes [$];
  int start_cyc [$];
  logic [7:0] rds [$];
  int rd_cyc [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic st;
    logic [7:0] r;
    @(negedge clk);
    cyc++;
    tx_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && auto_on) tx_done = 1'b1;
    end
    if (stray) begin
      tx_done = 1'b1;
      stray = 0;
    end
    st = use0 ? txs0 : txs1;
    r  = use0 ? rd0 : rd1;
    if (st) begin
      bytes.push_back(use0 ? txd0 : txd1);
      start_cyc.push_back(cyc);
      cd = 5;
    end
    if (|r) begin
      rds.push_back(r);
      rd_cyc.push_back(cyc);
    end
    if ($countones(rd0) > 1 || $countones(rd1) > 1 || (st && prev_s)) viol++;
    prev_s = st;
  endtask
  task automatic push(input int st, input logic [15:0] w);
    mem[st][wp[st]] = w;
    wp[st]++;
  endtask
  task automatic clr();
    bytes.delete();
    start_cyc.delete();
    rds.delete();
    rd_cyc.delete();
    cd = 0;
  endtask
  task automatic wait_bytes(input int n, input int budget);
    for (int k = 0; k < budget && bytes.size() < n; k++) tick();
    chk("byte_timeout", 32'(bytes.size() >= n), 32'd1);
  endtask
  task automatic wait_rds(input int n, input int budget);
    for (int k = 0; k < budget && rds.size() < n; k++) tick();
    chk("rd_timeout", 32'(rds.size() >= n), 32'd1);
  endtask
  initial begin
    int c0;
    for (int i = 0; i < 8; i++) wp[i] = 0;
    reset = 1; flag0 = 0; flag1 = 0; tx_done = 0; sel = 8'h00;
    repeat (3) tick();
    chk("rst_rd", 32'(rd1), 32'h0);
    chk("rst_txd", 32'(txd1), 32'h0);
    chk("rst_txs", 32'(txs1), 32'h0);
    chk("rst_cur", 32'(cur1), 32'h0);
    chk("rst_act", 32'(act1), 32'h0);
    chk("rst_act0", 32'(act0), 32'h0);
    reset = 0;
    tick();
    push(2, 16'hBEEF);
    sel = 8'h04; flag1 = 1; clr(); c0 = cyc;
    wait_bytes(3, 100);
    chk("t1_rd_cyc", 32'(rd_cyc[0] - c0), 32'd2);
    chk("t1_start_cyc", 32'(start_cyc[0] - c0), 32'd4);
    chk("t1_hdr", 32'(bytes[0]), 32'hA2);
    chk("t1_hi", 32'(bytes[1]), 32'hBE);
    chk("t1_lo", 32'(bytes[2]), 32'hEF);
    chk("t1_cur", 32'(cur1), 32'd2);
    repeat (12) tick();
    chk("t1_rd_cnt", 32'(rds.size()), 32'd1);
    chk("t1_rd_val", 32'(rds[0]), 32'h04);
    chk("t1_scan", 32'(act1), 32'd1);
    reset = 1;
    tick();
    push(1, 16'h1A01); push(1, 16'h1A02);
    push(3, 16'h3B01); push(3, 16'h3B02);
    push(6, 16'h6C01); push(6, 16'h6C02);
    sel = 8'hFF;
    tick();
    reset = 0; clr();
    wait_rds(6, 600);
    wait_bytes(18, 300);
    repeat (20) tick();
    chk("t2_rd_cnt", 32'(rds.size()), 32'd6);
    chk("t2_g0", 32'(rds[0]), 32'h02);
    chk("t2_g1", 32'(rds[1]), 32'h08);
    chk("t2_g2", 32'(rds[2]), 32'h40);
    chk("t2_g3", 32'(rds[3]), 32'h02);
    chk("t2_g4", 32'(rds[4]), 32'h08);
    chk("t2_g5", 32'(rds[5]), 32'h40);
    chk("t2_b0", 32'(bytes[0]), 32'hA1);
    chk("t2_b3", 32'(bytes[3]), 32'hA3);
    chk("t2_b9", 32'(bytes[9]), 32'hA1);
    chk("t2_b10", 32'(bytes[10]), 32'h1A);
    chk("t2_b11", 32'(bytes[11]), 32'h02);
    chk("t2_b17", 32'(bytes[17]), 32'h02);
    chk("t2_nbytes", 32'(bytes.size()), 32'd18);
    flag1 = 0; reset = 1;
    repeat (2) tick();
    push(0, 16'h1234); push(0, 16'h5678);
    sel = 8'h01; reset = 0; use0 = 1; flag0 = 1; clr();
    wait_bytes(4, 200);
    repeat (15) tick();
    chk("t3_b0", 32'(bytes[0]), 32'h12);
    chk("t3_b1", 32'(bytes[1]), 32'h34);
    chk("t3_b2", 32'(bytes[2]), 32'h56);
    chk("t3_b3", 32'(bytes[3]), 32'h78);
    chk("t3_nbytes", 32'(bytes.size()), 32'd4);
    chk("t3_rd_cnt", 32'(rds.size()), 32'd2);
    chk("t3_rd_val", 32'(rds[1]), 32'h01);
    chk("t3_other_idle", 32'(act1), 32'd0);
    flag0 = 0; use0 = 0; reset = 1;
    repeat (2) tick();
    push(5, 16'hC0DE); push(5, 16'h1111);
    sel = 8'h20; reset = 0; flag1 = 1; clr();
    wait_bytes(2, 100);
    tick();
    flag1 = 0;
    wait_bytes(3, 100);
    s = start_cyc[2];
    while (cyc < s + 5) tick();
    chk("t4_wait_lo", 32'(act1), 32'd1);
    tick();
    chk("t4_idle", 32'(act1), 32'd0);
    repeat (10) tick();
    chk("t4_rd_cnt", 32'(rds.size()), 32'd1);
    chk("t4_b0", 32'(bytes[0]), 32'hA5);
    chk("t4_b1", 32'(bytes[1]), 32'hC0);
    chk("t4_b2", 32'(bytes[2]), 32'hDE);
    push(7, 16'h7A7A); push(7, 16'h7B7B);
    sel = 8'hA0; flag1 = 1; clr();
    wait_bytes(2, 100);
    tick();
    chk("t5_first", 32'(rds[0]), 32'h80);
    reset = 1; auto_on = 0;
    tick();
    chk("t5_act", 32'(act1), 32'd0);
    chk("t5_txs", 32'(txs1), 32'd0);
    chk("t5_txd", 32'(txd1), 32'h0);
    chk("t5_rd", 32'(rd1), 32'h0);
    chk("t5_cur", 32'(cur1), 32'd0);
    flag1 = 0; reset = 0; clr(); stray = 1;
    repeat (4) tick();
    chk("t5_stray_act", 32'(act1), 32'd0);
    chk("t5_stray_bytes", 32'(bytes.size()), 32'd0);
    chk("t5_stray_rd", 32'(rds.size()), 32'd0);
    auto_on = 1; flag1 = 1;
    wait_rds(1, 20);
    chk("t5_regrant", 32'(rds[0]), 32'h20);
    reset = 1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) push(i, 16'h0F00 + 16'(i));
    sel = 8'h00; reset = 0; clr();
    repeat (10) tick();
    chk("t6_rd", 32'(rds.size()), 32'd0);
    chk("t6_bytes", 32'(bytes.size()), 32'd0);
    chk("t6_scan", 32'(act1), 32'd1);
    chk("t6_cur", 32'(cur1), 32'd0);
    stray = 1;
    repeat (5) tick();
    chk("t6_stray_rd", 32'(rds.size()), 32'd0);
    chk("t6_stray_bytes", 32'(bytes.size()), 32'd0);
    chk("t6_stray_scan", 32'(act1), 32'd1);
    chk("strobe_legal", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
